microwave_timer: RTL and testbench

- Cook-time controller that sequences the microwave cooking FSM.
- User sets a BCD MM:SS time with keypad pulses, then starts cooking. The block pulses `start` into the cooking FSM and counts down while heating.
- On expiry it pulses `finish` so the cooking FSM moves to its ring state.
- Sits between the debounced keypad/door sensor and the cooking FSM; also drives the time display.

---
 rtl/mw_pkg.sv | 74 +++++++
 rtl/bcd_time_counter.sv | 45 ++++
 rtl/microwave_timer.sv | 132 +++++++++++++
 tb/tb_microwave_timer.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mw_pkg.sv
// Shared types and BCD helpers for the microwave cook timer.
// Time is held as four packed BCD digits, MM:SS.
package mw_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SET,
      RUN,
      HOLD,
      DONE
   } state_t;

   typedef struct packed {
      logic [3:0] min_t;
      logic [3:0] min_o;
      logic [3:0] sec_t;
      logic [3:0] sec_o;
   } bcd_time_t;

   localparam int MAX_MIN   = 99;
   localparam int MAX_SEC_T = 5;

   localparam logic [3:0] MIN_T_MAX = 4'(MAX_MIN / 10);
   localparam logic [3:0] MIN_O_MAX = 4'(MAX_MIN % 10);
   localparam logic [3:0] SEC_T_MAX = 4'(MAX_SEC_T);

   function automatic bcd_time_t bcd_inc_min(bcd_time_t t);
      bcd_time_t r;
      r = t;
      if (t.min_o == 4'd9) begin
         r.min_o = 4'd0;
         r.min_t = t.min_t + 4'd1;
      end else begin
         r.min_o = t.min_o + 4'd1;
      end
      return r;
   endfunction

   function automatic bcd_time_t bcd_inc_sec10(bcd_time_t t);
      bcd_time_t r;
      r = t;
      if (t.sec_t == SEC_T_MAX) begin
         r.sec_t = 4'd0;
         r = bcd_inc_min(r);
      end else begin
         r.sec_t = t.sec_t + 4'd1;
      end
      return r;
   endfunction

   // Borrow ripples sec_o -> sec_t -> min_o -> min_t.
   function automatic bcd_time_t bcd_dec(bcd_time_t t);
      bcd_time_t r;
      r = t;
      if (t.sec_o != 4'd0) begin
         r.sec_o = t.sec_o - 4'd1;
      end else begin
         r.sec_o = 4'd9;
         if (t.sec_t != 4'd0) begin
            r.sec_t = t.sec_t - 4'd1;
         end else begin
            r.sec_t = SEC_T_MAX;
            if (t.min_o != 4'd0) begin
               r.min_o = t.min_o - 4'd1;
            end else begin
               r.min_o = 4'd9;
               r.min_t = t.min_t - 4'd1;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// BCD MM:SS register for the cook timer.
// A decrement is applied first and any add lands on the decremented value.
module bcd_time_counter
   import mw_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      clr,
   input  logic      add_min,
   input  logic      add_sec10,
   input  logic      dec,
   output bcd_time_t cur_time,
   output logic      is_zero,
   output logic      add_ok
);

   bcd_time_t t_q;
   bcd_time_t base;
   bcd_time_t t_d;
   logic      min_ok;
   logic      sec_ok;

   always_comb begin
      base   = dec ? bcd_dec(t_q) : t_q;
      min_ok = !(base.min_t == MIN_T_MAX && base.min_o == MIN_O_MAX);
      sec_ok = (base.sec_t < SEC_T_MAX) || min_ok;
      add_ok = add_min ? min_ok : (add_sec10 & sec_ok);
      t_d    = base;
      if (add_min && min_ok)
         t_d = bcd_inc_min(base);
      else if (!add_min && add_sec10 && sec_ok)
         t_d = bcd_inc_sec10(base);
   end

   always_ff @(posedge clk) begin
      if (rst || clr)
         t_q <= '0;
      else
         t_q <= t_d;
   end

   assign cur_time = t_q;
   assign is_zero  = (t_q == '0);

endmodule

// File: rtl/microwave_timer.sv
// Cook-time controller: keypad time entry, start/finish pulses
// to the cooking FSM, and heat-gated countdown.
module microwave_timer
   import mw_pkg::*;
#(
   parameter int TICKS_PER_SEC = 50_000_000
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       door,
   input  logic       heat,
   input  logic       btn_min,
   input  logic       btn_sec10,
   input  logic       btn_start,
   input  logic       btn_stop,
   output logic       start,
   output logic       finish,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic       busy
);

   localparam int PW = $clog2(TICKS_PER_SEC);
   localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);
   localparam bcd_time_t ONE_SEC = 16'h0001;

   state_t        state;
   state_t        nstate;
   logic [PW-1:0] presc;
   logic          door_q;
   logic          tick;
   logic          last;
   logic          door_rise;
   logic          start_go;
   logic          clr;
   logic          add_en;
   logic          add_min;
   logic          add_sec10;
   bcd_time_t     cur_time;
   logic          is_zero;
   logic          add_ok;

   bcd_time_counter u_time (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .add_min   (add_min),
      .add_sec10 (add_sec10),
      .dec       (tick),
      .cur_time  (cur_time),
      .is_zero   (is_zero),
      .add_ok    (add_ok)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= nstate;
   end

   always_comb begin
      nstate = state;
      unique case (state)
         IDLE: if ((add_min || add_sec10) && add_ok) nstate = SET;
         SET: begin
            if (clr)
               nstate = IDLE;
            else if (start_go)
               nstate = RUN;
         end
         RUN: begin
            if (last)
               nstate = DONE;
            else if (door)
               nstate = HOLD;
         end
         HOLD: if (!door) nstate = RUN;
         DONE: if (btn_stop || door_rise) nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   // Expiry beats door and adds; stop/start in SET swallow adds.
   always_comb begin
      tick      = (state == RUN) && heat && (presc == PMAX);
      last      = tick && (cur_time == ONE_SEC);
      door_rise = door && !door_q;
      clr       = (state == SET) && btn_stop;
      start_go  = (state == SET) && !btn_stop && btn_start
                  && !door && !is_zero;
      add_en    = 1'b0;
      unique case (state)
         IDLE:    add_en = 1'b1;
         SET:     add_en = !btn_stop && !start_go;
         RUN:     add_en = !last;
         HOLD:    add_en = 1'b1;
         DONE:    add_en = 1'b0;
         default: add_en = 1'b0;
      endcase
      add_min   = add_en && btn_min;
      add_sec10 = add_en && btn_sec10 && !btn_min;
   end

   always_ff @(posedge clk) begin
      if (rst)
         presc <= '0;
      else if (start_go)
         presc <= '0;
      else if (state == RUN && heat)
         presc <= (presc == PMAX) ? '0 : presc + PW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         door_q <= 1'b0;
         start  <= 1'b0;
         finish <= 1'b0;
         busy   <= 1'b0;
      end else begin
         door_q <= door;
         start  <= start_go;
         finish <= last;
         busy   <= (nstate == RUN) || (nstate == HOLD);
      end
   end

   assign min_bcd = {cur_time.min_t, cur_time.min_o};
   assign sec_bcd = {cur_time.sec_t, cur_time.sec_o};

endmodule

// File: tb/tb_microwave_timer.sv
// Self-checking bench for microwave_timer against a
// seconds-count reference model.
module tb_microwave_timer;

   localparam int T    = 4;
   localparam int TMAX = 99 * 60 + 59;
   localparam int S_IDLE = 0;
   localparam int S_SET  = 1;
   localparam int S_RUN  = 2;
   localparam int S_HOLD = 3;
   localparam int S_DONE = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       door = 1'b0;
   logic       heat = 1'b0;
   logic       btn_min = 1'b0;
   logic       btn_sec10 = 1'b0;
   logic       btn_start = 1'b0;
   logic       btn_stop = 1'b0;
   logic       start;
   logic       finish;
   logic [7:0] min_bcd;
   logic [7:0] sec_bcd;
   logic       busy;

   int errors = 0;
   int checks = 0;

   int m_state = S_IDLE;
   int m_secs  = 0;
   int m_presc = 0;
   bit m_door_q = 1'b0;
   bit m_start = 1'b0;
   bit m_finish = 1'b0;

   wire [18:0] dutv = {start, finish, busy, min_bcd, sec_bcd};

   always #5 clk = ~clk;

   microwave_timer #(.TICKS_PER_SEC(T)) dut (
      .clk       (clk),
      .rst       (rst),
      .door      (door),
      .heat      (heat),
      .btn_min   (btn_min),
      .btn_sec10 (btn_sec10),
      .btn_start (btn_start),
      .btn_stop  (btn_stop),
      .start     (start),
      .finish    (finish),
      .min_bcd   (min_bcd),
      .sec_bcd   (sec_bcd),
      .busy      (busy)
   );

   function automatic int add_t(input int b);
      if (btn_min)
         return (b + 60 <= TMAX) ? b + 60 : b;
      if (btn_sec10)
         return (b + 10 <= TMAX) ? b + 10 : b;
      return b;
   endfunction

   function automatic logic [7:0] to_bcd(input int v);
      logic [3:0] h;
      logic [3:0] l;
      h = 4'(v / 10);
      l = 4'(v % 10);
      return {h, l};
   endfunction

   function automatic logic [18:0] expv();
      bit b;
      b = (m_state == S_RUN) || (m_state == S_HOLD);
      return {m_start, m_finish, b,
              to_bcd(m_secs / 60), to_bcd(m_secs % 60)};
   endfunction

   task automatic model_step();
      bit tk;
      int base;
      m_start  = 1'b0;
      m_finish = 1'b0;
      if (rst) begin
         m_state = S_IDLE;
         m_secs  = 0;
         m_presc = 0;
      end else begin
         case (m_state)
            S_IDLE: begin
               m_secs = add_t(m_secs);
               if (m_secs > 0) m_state = S_SET;
            end
            S_SET: begin
               if (btn_stop) begin
                  m_secs  = 0;
                  m_state = S_IDLE;
               end else if (btn_start && !door) begin
                  m_state = S_RUN;
                  m_presc = 0;
                  m_start = 1'b1;
               end else begin
                  m_secs = add_t(m_secs);
               end
            end
            S_RUN: begin
               tk = heat && (m_presc == T - 1);
               if (heat) m_presc = (m_presc + 1) % T;
               if (tk && m_secs == 1) begin
                  m_secs   = 0;
                  m_state  = S_DONE;
                  m_finish = 1'b1;
               end else begin
                  base   = tk ? m_secs - 1 : m_secs;
                  m_secs = add_t(base);
                  if (door) m_state = S_HOLD;
               end
            end
            S_HOLD: begin
               m_secs = add_t(m_secs);
               if (!door) m_state = S_RUN;
            end
            default: begin
               if (btn_stop || (door && !m_door_q)) m_state = S_IDLE;
            end
         endcase
      end
      m_door_q = rst ? 1'b0 : door;
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      btn_min   = 1'b0;
      btn_sec10 = 1'b0;
      btn_start = 1'b0;
      btn_stop  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      door = 1'b0;
      heat = 1'b0;
      do_reset();
      checks++;
      if ({start, finish, busy} !== 3'b000) begin
         errors++;
         $display("FAIL reset_ctl: got %b expected 000", {start, finish, busy});
      end
      checks++;
      if ({min_bcd, sec_bcd} !== 16'h0000) begin
         errors++;
         $display("FAIL reset_time: got %h expected 0000", {min_bcd, sec_bcd});
      end
   endtask

   task automatic test_basic_cook();
      int fins;
      fins = 0;
      do_reset();
      btn_sec10 = 1'b1;
      step();
      btn_sec10 = 1'b1;
      step();
      heat = 1'b1;
      btn_start = 1'b1;
      step();
      checks++;
      if ({start, busy} !== 2'b11) begin
         errors++;
         $display("FAIL basic_start: got %b expected 11", {start, busy});
      end
      step();
      checks++;
      if (start !== 1'b0) begin
         errors++;
         $display("FAIL basic_start_len: got %b expected 0", start);
      end
      for (int i = 0; i < 80; i++) begin
         step();
         if (finish === 1'b1) fins++;
         checks++;
         if (dutv !== expv()) begin
            errors++;
            $display("FAIL basic_cyc%0d: got %h expected %h", i, dutv, expv());
         end
      end
      checks++;
      if (fins != 1) begin
         errors++;
         $display("FAIL basic_finish_count: got %0d expected 1", fins);
      end
      checks++;
      if ({busy, sec_bcd, min_bcd} !== 17'h0) begin
         errors++;
         $display("FAIL basic_done: got %h expected 0", {busy, sec_bcd, min_bcd});
      end
      heat = 1'b0;
   endtask

   task automatic test_borrow_hold();
      do_reset();
      btn_min = 1'b1;
      step();
      heat = 1'b1;
      btn_start = 1'b1;
      step();
      repeat (4) step();
      checks++;
      if ({min_bcd, sec_bcd} !== 16'h0059) begin
         errors++;
         $display("FAIL borrow: got %h expected 0059", {min_bcd, sec_bcd});
      end
      repeat (2) step();
      door = 1'b1;
      heat = 1'b0;
      repeat (20) begin
         step();
         checks++;
         if (dutv !== expv()) begin
            errors++;
            $display("FAIL hold_cyc: got %h expected %h", dutv, expv());
         end
      end
      checks++;
      if ({busy, min_bcd, sec_bcd} !== 17'h10059) begin
         errors++;
         $display("FAIL hold_frozen: got %h expected 10059", {busy, min_bcd, sec_bcd});
      end
      door = 1'b0;
      heat = 1'b1;
      repeat (2) step();
      checks++;
      if (sec_bcd !== 8'h59) begin
         errors++;
         $display("FAIL resume_early: got %h expected 59", sec_bcd);
      end
      step();
      checks++;
      if (sec_bcd !== 8'h58) begin
         errors++;
         $display("FAIL resume_tick: got %h expected 58", sec_bcd);
      end
      heat = 1'b0;
   endtask

   task automatic test_overflow();
      do_reset();
      repeat (99) begin
         btn_min = 1'b1;
         step();
      end
      repeat (5) begin
         btn_sec10 = 1'b1;
         step();
      end
      btn_sec10 = 1'b1;
      step();
      checks++;
      if ({min_bcd, sec_bcd} !== 16'h9950) begin
         errors++;
         $display("FAIL ovf_sec10: got %h expected 9950", {min_bcd, sec_bcd});
      end
      btn_min = 1'b1;
      step();
      checks++;
      if ({min_bcd, sec_bcd} !== 16'h9950) begin
         errors++;
         $display("FAIL ovf_min: got %h expected 9950", {min_bcd, sec_bcd});
      end
      btn_stop = 1'b1;
      step();
      repeat (98) begin
         btn_min = 1'b1;
         step();
      end
      repeat (5) begin
         btn_sec10 = 1'b1;
         step();
      end
      btn_sec10 = 1'b1;
      step();
      checks++;
      if ({min_bcd, sec_bcd} !== 16'h9900) begin
         errors++;
         $display("FAIL carry_9900: got %h expected 9900", {min_bcd, sec_bcd});
      end
   endtask

   task automatic test_start_ignored();
      do_reset();
      btn_start = 1'b1;
      step();
      checks++;
      if ({start, busy, min_bcd, sec_bcd} !== 18'h0) begin
         errors++;
         $display("FAIL start_idle: got %h expected 0", {start, busy, min_bcd, sec_bcd});
      end
      btn_sec10 = 1'b1;
      step();
      door = 1'b1;
      btn_start = 1'b1;
      step();
      step();
      checks++;
      if ({start, busy, sec_bcd} !== 10'h010) begin
         errors++;
         $display("FAIL start_door: got %h expected 010", {start, busy, sec_bcd});
      end
      door = 1'b0;
   endtask

   task automatic test_final_tick_door();
      do_reset();
      btn_sec10 = 1'b1;
      step();
      heat = 1'b1;
      btn_start = 1'b1;
      step();
      repeat (36 + 3) step();
      checks++;
      if (sec_bcd !== 8'h01) begin
         errors++;
         $display("FAIL pre_final: got %h expected 01", sec_bcd);
      end
      door = 1'b1;
      step();
      checks++;
      if ({finish, busy, sec_bcd} !== 10'h200) begin
         errors++;
         $display("FAIL final_door: got %h expected 200", {finish, busy, sec_bcd});
      end
      heat = 1'b0;
      door = 1'b0;
      btn_sec10 = 1'b1;
      step();
      checks++;
      if ({finish, sec_bcd} !== 9'h000) begin
         errors++;
         $display("FAIL done_add: got %h expected 000", {finish, sec_bcd});
      end
      door = 1'b1;
      step();
      door = 1'b0;
      btn_sec10 = 1'b1;
      step();
      checks++;
      if ({busy, sec_bcd} !== 9'h010) begin
         errors++;
         $display("FAIL done_exit: got %h expected 010", {busy, sec_bcd});
      end
   endtask

   task automatic test_reset_midcook();
      do_reset();
      repeat (5) begin
         btn_min = 1'b1;
         step();
      end
      repeat (3) begin
         btn_sec10 = 1'b1;
         step();
      end
      heat = 1'b1;
      btn_start = 1'b1;
      step();
      btn_stop = 1'b1;
      step();
      checks++;
      if ({busy, min_bcd, sec_bcd} !== 17'h10530) begin
         errors++;
         $display("FAIL stop_run: got %h expected 10530", {busy, min_bcd, sec_bcd});
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if ({start, finish, busy, min_bcd, sec_bcd} !== 19'h0) begin
         errors++;
         $display("FAIL rst_run: got %h expected 0", {start, finish, busy, min_bcd, sec_bcd});
      end
      heat = 1'b0;
      btn_sec10 = 1'b1;
      step();
      btn_stop = 1'b1;
      step();
      btn_start = 1'b1;
      step();
      checks++;
      if ({start, busy, min_bcd, sec_bcd} !== 18'h0) begin
         errors++;
         $display("FAIL stop_set: got %h expected 0", {start, busy, min_bcd, sec_bcd});
      end
   endtask

   task automatic test_random();
      int r;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 199);
         btn_min   = (r < 2);
         btn_sec10 = (r >= 2 && r < 5);
         btn_start = (r >= 5 && r < 20);
         btn_stop  = (r >= 20 && r < 24);
         if ($urandom_range(0, 29) == 0) btn_min = 1'b1;
         heat = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 24) == 0) door = ~door;
         rst = ($urandom_range(0, 999) == 0);
         step();
         checks++;
         if (dutv !== expv()) begin
            errors++;
            $display("FAIL rand_cyc%0d: got %h expected %h", i, dutv, expv());
         end
      end
      rst  = 1'b0;
      door = 1'b0;
      heat = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic_cook();
      test_borrow_hold();
      test_overflow();
      test_start_ignored();
      test_final_tick_door();
      test_reset_midcook();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
